priority_scan_encoder: RTL and testbench

//  Sequential successor of the flat 128-bit priority encoder.

---
 rtl/priority_scan_encoder_if.sv | 33 +++
 rtl/priority_scan_encoder.sv | 112 +++++++++++
 tb/tb_priority_scan_encoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/priority_scan_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priority_scan_encoder_if : request-in / index-beat-out bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface priority_scan_encoder_if #(
  parameter int WIDTH = 128
) ();
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_none;
  logic             out_last;
  logic [CNT_W-1:0] out_total;

  modport slave (
    input  flush, in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_last, out_total
  );

  modport master (
    output flush, in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_last, out_total
  );
endinterface
`default_nettype wire

// File: rtl/priority_scan_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priority_scan_encoder : emits the index of every set request bit, one per
// beat, in priority order.   Revision 1.0
// ---------------------------------------------------------------------------
module priority_scan_encoder #(
  parameter int WIDTH      = 128,
  parameter int HIGH_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  priority_scan_encoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             none_q, none_d;
  logic             last_q, last_d;
  logic             beat;
  logic             accept;
  logic             in_ready;

  function automatic logic [IDX_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    total_d  = total_q;
    beat     = (state_q == S_SCAN) && bus.out_ready;
    in_ready = (state_q == S_IDLE) || (beat && last_q);
    accept   = bus.in_valid && in_ready;

    if (beat) begin
      rem_d = rem_q & ~(WIDTH'(1) << idx_q);
      if (last_q) state_d = S_IDLE;
    end
    if (accept) begin
      rem_d   = bus.in_vec;
      total_d = popcount(bus.in_vec);
      state_d = S_SCAN;
    end
    // Abort wins over both handshakes; the consumer discards that beat.
    if (bus.flush) begin
      rem_d   = '0;
      state_d = S_IDLE;
    end

    // Beat fields are pre-decoded from the next remainder so they leave flops.
    idx_d  = prio_idx(rem_d);
    none_d = (rem_d == '0);
    last_d = none_d || ((rem_d & ~(WIDTH'(1) << idx_d)) == '0);
    if (state_d == S_IDLE) begin
      idx_d  = '0;
      none_d = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      total_q <= '0;
      idx_q   <= '0;
      none_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_SCAN);
  assign bus.out_idx   = idx_q;
  assign bus.out_none  = none_q;
  assign bus.out_last  = last_q;
  assign bus.out_total = total_q;
endmodule
`default_nettype wire

// File: tb/tb_priority_scan_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_priority_scan_encoder : lockstep bench for high-first and low-first scans
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_priority_scan_encoder;
  localparam int WIDTH = 128;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_vec;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  // Reference: pending indices for each order, plus the accepted vector's facts.
  int  q_hi[$];
  int  q_lo[$];
  bit  busy    = 1'b0;
  bit  empty_v = 1'b0;
  int  total_m = 0;

  priority_scan_encoder_if #(.WIDTH(WIDTH)) if_hi ();
  priority_scan_encoder_if #(.WIDTH(WIDTH)) if_lo ();

  assign if_hi.flush     = flush;
  assign if_hi.in_valid  = in_valid;
  assign if_hi.in_vec    = in_vec;
  assign if_hi.out_ready = out_ready;
  assign if_lo.flush     = flush;
  assign if_lo.in_valid  = in_valid;
  assign if_lo.in_vec    = in_vec;
  assign if_lo.out_ready = out_ready;

  priority_scan_encoder #(.WIDTH(WIDTH), .HIGH_FIRST(1)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_hi.slave)
  );

  priority_scan_encoder #(.WIDTH(WIDTH), .HIGH_FIRST(0)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_lo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [WIDTH-1:0] v);
    q_hi.delete();
    q_lo.delete();
    total_m = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        q_lo.push_back(i);
        q_hi.push_front(i);
        total_m++;
      end
    end
    empty_v = (total_m == 0);
    if (empty_v) begin
      q_hi.push_back(0);
      q_lo.push_back(0);
    end
    busy = 1'b1;
  endtask

  task automatic model_clear();
    q_hi.delete();
    q_lo.delete();
    busy = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid_hi", 32'(if_hi.out_valid), 32'(busy));
    chk("out_valid_lo", 32'(if_lo.out_valid), 32'(busy));
    if (busy) begin
      chk("idx_hi",   32'(if_hi.out_idx),   32'(q_hi[0]));
      chk("idx_lo",   32'(if_lo.out_idx),   32'(q_lo[0]));
      chk("none_hi",  32'(if_hi.out_none),  32'(empty_v));
      chk("none_lo",  32'(if_lo.out_none),  32'(empty_v));
      chk("last_hi",  32'(if_hi.out_last),  32'(q_hi.size() == 1));
      chk("last_lo",  32'(if_lo.out_last),  32'(q_lo.size() == 1));
      chk("total_hi", 32'(if_hi.out_total), 32'(total_m));
      chk("total_lo", 32'(if_lo.out_total), 32'(total_m));
    end
  endtask

  // Called just after a rising edge: drive, check, advance one clock.
  task automatic step(input bit v, input logic [WIDTH-1:0] vec, input bit rdy, input bit fl);
    bit exp_ready;
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    flush     = fl;
    #1;
    check_outputs();
    exp_ready = !busy || (rdy && q_hi.size() == 1);
    chk("in_ready_hi", 32'(if_hi.in_ready), 32'(exp_ready));
    chk("in_ready_lo", 32'(if_lo.in_ready), 32'(exp_ready));
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (busy && rdy) begin
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
        if (q_hi.size() == 0) busy = 1'b0;
      end
      if (v && exp_ready) model_load(vec);
    end
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_vec();
    logic [WIDTH-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = '0;
      1: r = r & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
               & {$urandom, $urandom, $urandom, $urandom};
      2: r = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [WIDTH-1:0] v_t2;
    logic [WIDTH-1:0] v_tmp;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    v_t2      = '0;
    v_t2[127] = 1'b1;
    v_t2[64]  = 1'b1;
    v_t2[3]   = 1'b1;
    v_t2[0]   = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(if_hi.out_valid), 32'd0);
    chk("rst_in_ready",  32'(if_hi.in_ready),  32'd1);
    chk("rst_idx",       32'(if_hi.out_idx),   32'd0);
    chk("rst_none",      32'(if_hi.out_none),  32'd0);
    chk("rst_last",      32'(if_hi.out_last),  32'd0);
    chk("rst_total",     32'(if_lo.out_total), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four set bits at the extremes, consumer always ready.
    step(1'b1, v_t2, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Bits 1 and 3, then an empty vector.
    step(1'b1, WIDTH'(128'hA), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure pattern 1,0,0,1 with input vector wiggling under the scan.
    step(1'b1, v_t2, 1'b1, 1'b0);
    step(1'b0, ~v_t2, 1'b1, 1'b0);
    step(1'b1, '1,    1'b0, 1'b0);
    step(1'b0, '0,    1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back: {5} offered on the final beat of {2,9}.
    v_tmp = '0; v_tmp[2] = 1'b1; v_tmp[9] = 1'b1;
    step(1'b1, v_tmp, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, WIDTH'(1) << 5, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush on the second beat, with a competing input offer.
    step(1'b1, v_t2, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, '1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, WIDTH'(1) << 10, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 1)), rand_vec(), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 49) == 0));
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a scan.
    step(1'b1, v_t2, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_out_valid_hi", 32'(if_hi.out_valid), 32'd0);
    chk("mid_rst_in_ready_hi",  32'(if_hi.in_ready),  32'd1);
    chk("mid_rst_out_valid_lo", 32'(if_lo.out_valid), 32'd0);
    chk("mid_rst_in_ready_lo",  32'(if_lo.in_ready),  32'd1);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, WIDTH'(1) << 77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
